// File: rtl/bus_share_arbiter.sv
// -----------------------------------------------------------------------------
// bus_share_arbiter
//
// Round-robin arbiter and sequencer that lets REQUESTERS upstream sources share
// one WIDTH-bit output register. One source owns the register at a time. Each
// accepted beat is acknowledged and steered into the register. Ownership is
// released when:
//   - the owner flags end-of-burst,
//   - the owner has moved MAX_HOLD beats, or
//   - the owner withdraws its request.
// The next arbitration then starts one past the old owner.
//
// Ports
//   clock      : system clock, rising edge
//   reset      : asynchronous active-high reset
//   clear      : synchronous clear, same effect as reset, highest priority
//   req        : per-source request (held while a beat is offered)
//   last       : per-source end-of-burst flag, qualified by the accepted beat
//   data_in    : per-source data word
//   ack        : combinational one-hot, beat of that source accepted this cycle
//   grant      : registered one-hot current owner, zero when idle
//   grant_id   : index of current owner, zero when idle
//   out_valid  : output register holds a valid beat
//   out_data   : output register contents
//   out_ready  : downstream takes out_data this cycle when out_valid is high
// -----------------------------------------------------------------------------
module bus_share_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int WIDTH      = 8,
  parameter int MAX_HOLD   = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clear,
  input  logic [REQUESTERS-1:0]            req,
  input  logic [REQUESTERS-1:0]            last,
  input  logic [REQUESTERS-1:0][WIDTH-1:0] data_in,
  output logic [REQUESTERS-1:0]            ack,
  output logic [REQUESTERS-1:0]            grant,
  output logic [$clog2(REQUESTERS)-1:0]    grant_id,
  output logic                             out_valid,
  output logic [WIDTH-1:0]                 out_data,
  input  logic                             out_ready
);

  localparam int ID_W  = $clog2(REQUESTERS);
  localparam int IDX_W = ID_W + 1;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ID_W-1:0]         ptr_r;
  logic [ID_W-1:0]         ptr_nxt_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic [REQUESTERS-1:0]   grant_r;
  logic [REQUESTERS-1:0]   grant_nxt_s;
  logic [ID_W-1:0]         grant_id_r;
  logic [ID_W-1:0]         grant_id_nxt_s;
  logic                    out_valid_r;
  logic [WIDTH-1:0]        out_data_r;

  logic [ID_W-1:0]         sel_id_s;
  logic                    any_req_s;
  logic                    owner_req_s;
  logic                    owner_last_s;
  logic                    accept_s;
  logic                    final_beat_s;
  logic [ID_W-1:0]         after_owner_s;
  logic [REQUESTERS-1:0]   ack_s;

  // Index to one-hot conversion for grant and ack vectors.
  function automatic logic [REQUESTERS-1:0] onehot_f(input logic [ID_W-1:0] id);
    logic [REQUESTERS-1:0] vec;
    vec     = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

  assign any_req_s    = |req;
  assign owner_req_s  = req[grant_id_r];
  assign owner_last_s = last[grant_id_r];

  // Only control inputs feed accept, never data_in. Clear and reset suppress it,
  // so no beat is taken in a clear cycle.
  assign accept_s = (state_r == ST_GRANT) && owner_req_s &&
                    (!out_valid_r || out_ready) && !clear && !reset;

  assign final_beat_s = owner_last_s || (cnt_r == CNT_W'(MAX_HOLD - 1));

  assign after_owner_s = (grant_id_r == ID_W'(REQUESTERS - 1)) ?
                         ID_W'(0) : grant_id_r + ID_W'(1);

  // Round-robin search: first requester at or after ptr, wrapping.
  always_comb begin : rr_select
    logic [IDX_W-1:0] sum_v;
    logic [ID_W-1:0]  idx_v;
    logic             found_v;
    sum_v    = '0;
    idx_v    = '0;
    found_v  = 1'b0;
    sel_id_s = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      sum_v    = {1'b0, ptr_r} + IDX_W'(k);
      sum_v    = (sum_v >= IDX_W'(REQUESTERS)) ? sum_v - IDX_W'(REQUESTERS) : sum_v;
      idx_v    = sum_v[ID_W-1:0];
      sel_id_s = (!found_v && req[idx_v]) ? idx_v : sel_id_s;
      found_v  = found_v | req[idx_v];
    end
  end

  // FSM state register together with pointer, beat count and grant registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      cnt_r      <= '0;
      grant_r    <= '0;
      grant_id_r <= '0;
    end else if (clear) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      cnt_r      <= '0;
      grant_r    <= '0;
      grant_id_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      ptr_r      <= ptr_nxt_s;
      cnt_r      <= cnt_nxt_s;
      grant_r    <= grant_nxt_s;
      grant_id_r <= grant_id_nxt_s;
    end
  end

  // FSM next-state logic: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    state_nxt_s    = state_r;
    ptr_nxt_s      = ptr_r;
    cnt_nxt_s      = cnt_r;
    grant_nxt_s    = grant_r;
    grant_id_nxt_s = grant_id_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s    = ST_GRANT;
          grant_id_nxt_s = sel_id_s;
          grant_nxt_s    = onehot_f(sel_id_s);
          cnt_nxt_s      = '0;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // Withdrawal and a final accepted beat both hand the turn to the next index.
        if (!owner_req_s || (accept_s && final_beat_s)) begin
          state_nxt_s    = ST_IDLE;
          ptr_nxt_s      = after_owner_s;
          cnt_nxt_s      = '0;
          grant_nxt_s    = '0;
          grant_id_nxt_s = '0;
        end else if (accept_s) begin
          cnt_nxt_s      = cnt_r + CNT_W'(1);
        end else begin
          state_nxt_s    = ST_GRANT;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        ptr_nxt_s      = '0;
        cnt_nxt_s      = '0;
        grant_nxt_s    = '0;
        grant_id_nxt_s = '0;
      end
    endcase
  end

  // FSM output logic: acknowledge the owner's beat when it is accepted.
  always_comb begin
    if (accept_s) begin
      ack_s = onehot_f(grant_id_r);
    end else begin
      ack_s = '0;
    end
  end

  // Output register: load on acceptance, drop valid once consumed, else hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (clear) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= data_in[grant_id_r];
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign ack       = ack_s;
  assign grant     = grant_r;
  assign grant_id  = grant_id_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_bus_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_share_arbiter
//
// Directed bench for bus_share_arbiter with its default parameters (4 sources,
// 8-bit data, 4-beat hold limit).
//
// Per cycle, every step does the following:
//   - drives the inputs;
//   - checks grant, grant_id and ack against the values written in the step;
//   - checks the output register against a scoreboard queue.
//
// Each expected-accepted beat is pushed to the queue. The queue head is what
// out_data must show while out_valid is high, and it is popped on a handshake.
// -----------------------------------------------------------------------------
module tb_bus_share_arbiter;

  logic             clock = 1'b0;
  logic             reset;
  logic             clear;
  logic [3:0]       req;
  logic [3:0]       last;
  logic [3:0][7:0]  data_in;
  logic [3:0]       ack;
  logic [3:0]       grant;
  logic [1:0]       grant_id;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_ready;

  int               vectors    = 0;
  int               miscompares = 0;
  logic [7:0]       exp_q[$];

  bus_share_arbiter #(
    .REQUESTERS (4),
    .WIDTH      (8),
    .MAX_HOLD   (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .req       (req),
    .last      (last),
    .data_in   (data_in),
    .ack       (ack),
    .grant     (grant),
    .grant_id  (grant_id),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] id_of(input logic [3:0] oh);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) id = 2'(i);
    end
    return id;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle. It starts 1 time unit after a rising edge. Outputs are sampled
  // 1 time unit after the inputs change. Non-owner lanes carry filler data
  // 8'hE0+lane so that wrong steering shows up.
  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l,
                      input logic rdy, input logic [1:0] lane, input logic [7:0] d,
                      input logic [3:0] eg, input logic [3:0] ea, input bit adv);
    req       = r;
    last      = l;
    out_ready = rdy;
    for (int j = 0; j < 4; j++) data_in[j] = 8'hE0 + 8'(j);
    data_in[lane] = d;
    #1;
    check({tag, " grant"},     32'(grant),     32'(eg));
    check({tag, " grant_id"},  32'(grant_id),  32'(id_of(eg)));
    check({tag, " ack"},       32'(ack),       32'(ea));
    check({tag, " out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check({tag, " out_data"}, 32'(out_data), 32'(exp_q[0]));
      if (rdy) void'(exp_q.pop_front());
    end
    if (ea != 4'b0000) exp_q.push_back(data_in[id_of(ea)]);
    if (adv) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " grant"},     32'(grant),     32'd0);
    check({tag, " grant_id"},  32'(grant_id),  32'd0);
    check({tag, " ack"},       32'(ack),       32'd0);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " out_data"},  32'(out_data),  32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    req       = 4'b0000;
    last      = 4'b0000;
    out_ready = 1'b1;
    data_in   = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    req = 4'b1111;
    #1;
    check_zero("reset");
    req   = 4'b0000;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Fairness: all sources request, one-beat bursts, grant order 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      step($sformatf("fair_idle%0d", k), 4'hF, 4'hF, 1'b1, 2'(k % 4), 8'h00,
           4'h0, 4'h0, 1'b1);
      step($sformatf("fair_gnt%0d", k), 4'hF, 4'hF, 1'b1, 2'(k % 4), 8'(k + 1),
           4'(1 << (k % 4)), 4'(1 << (k % 4)), 1'b1);
    end
    step("fair_end",   4'h0, 4'h0, 1'b1, 2'd0, 8'h00, 4'h0, 4'h0, 1'b1);
    step("fair_drain", 4'h0, 4'h0, 1'b1, 2'd0, 8'h00, 4'h0, 4'h0, 1'b1);

    // Single source, three-beat burst from source 1.
    step("ss0", 4'b0010, 4'b0000, 1'b1, 2'd1, 8'h11, 4'b0000, 4'b0000, 1'b1);
    step("ss1", 4'b0010, 4'b0000, 1'b1, 2'd1, 8'h11, 4'b0010, 4'b0010, 1'b1);
    step("ss2", 4'b0010, 4'b0000, 1'b1, 2'd1, 8'h22, 4'b0010, 4'b0010, 1'b1);
    step("ss3", 4'b0010, 4'b0010, 1'b1, 2'd1, 8'h33, 4'b0010, 4'b0010, 1'b1);
    step("ss4", 4'b0000, 4'b0000, 1'b1, 2'd1, 8'h00, 4'b0000, 4'b0000, 1'b1);

    // The pointer now sits at 2: sources 1 and 2 requesting must give 2, then 1.
    step("pt0", 4'b0110, 4'b0110, 1'b1, 2'd2, 8'h44, 4'b0000, 4'b0000, 1'b1);
    step("pt1", 4'b0110, 4'b0110, 1'b1, 2'd2, 8'h44, 4'b0100, 4'b0100, 1'b1);
    step("pt2", 4'b0110, 4'b0110, 1'b1, 2'd1, 8'h55, 4'b0000, 4'b0000, 1'b1);
    step("pt3", 4'b0110, 4'b0110, 1'b1, 2'd1, 8'h55, 4'b0010, 4'b0010, 1'b1);
    step("pt4", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'h00, 4'b0000, 4'b0000, 1'b1);

    // Hold limit: source 2 streams six beats without last, split 4 + 2.
    step("mh0", 4'b0100, 4'b0000, 1'b1, 2'd2, 8'h61, 4'b0000, 4'b0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step($sformatf("mh_beat%0d", k), 4'b0100, 4'b0000, 1'b1, 2'd2, 8'h61 + 8'(k),
           4'b0100, 4'b0100, 1'b1);
    end
    step("mh_gap", 4'b0100, 4'b0000, 1'b1, 2'd2, 8'h65, 4'b0000, 4'b0000, 1'b1);
    step("mh5",    4'b0100, 4'b0000, 1'b1, 2'd2, 8'h65, 4'b0100, 4'b0100, 1'b1);
    step("mh6",    4'b0100, 4'b0100, 1'b1, 2'd2, 8'h66, 4'b0100, 4'b0100, 1'b1);
    step("mh7",    4'b0000, 4'b0000, 1'b1, 2'd0, 8'h00, 4'b0000, 4'b0000, 1'b1);
    step("mh8",    4'b0000, 4'b0000, 1'b1, 2'd0, 8'h00, 4'b0000, 4'b0000, 1'b1);

    // Backpressure: three stalled cycles mid-burst on source 0.
    step("bp0", 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h71, 4'b0000, 4'b0000, 1'b1);
    step("bp1", 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h71, 4'b0001, 4'b0001, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step($sformatf("bp_stall%0d", k), 4'b0001, 4'b0000, 1'b0, 2'd0, 8'h72,
           4'b0001, 4'b0000, 1'b1);
    end
    step("bp_resume", 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h72, 4'b0001, 4'b0001, 1'b1);
    step("bp6",       4'b0001, 4'b0000, 1'b1, 2'd0, 8'h73, 4'b0001, 4'b0001, 1'b1);
    step("bp7",       4'b0001, 4'b0001, 1'b1, 2'd0, 8'h74, 4'b0001, 4'b0001, 1'b1);
    step("bp8",       4'b0000, 4'b0000, 1'b1, 2'd0, 8'h00, 4'b0000, 4'b0000, 1'b1);
    step("bp9",       4'b0000, 4'b0000, 1'b1, 2'd0, 8'h00, 4'b0000, 4'b0000, 1'b1);

    // Withdrawal: owner 3 drops after one beat while source 0 waits.
    step("wd0", 4'b1001, 4'b0000, 1'b1, 2'd3, 8'h81, 4'b0000, 4'b0000, 1'b1);
    step("wd1", 4'b1001, 4'b0000, 1'b1, 2'd3, 8'h81, 4'b1000, 4'b1000, 1'b1);
    step("wd2", 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h82, 4'b1000, 4'b0000, 1'b1);
    step("wd3", 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h82, 4'b0000, 4'b0000, 1'b1);
    step("wd4", 4'b0001, 4'b0001, 1'b1, 2'd0, 8'h82, 4'b0001, 4'b0001, 1'b1);
    step("wd5", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'h00, 4'b0000, 4'b0000, 1'b1);
    step("wd6", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'h00, 4'b0000, 4'b0000, 1'b1);

    // Asynchronous reset mid-burst on source 1.
    step("rs0", 4'b0010, 4'b0000, 1'b1, 2'd1, 8'h91, 4'b0000, 4'b0000, 1'b1);
    step("rs1", 4'b0010, 4'b0000, 1'b1, 2'd1, 8'h91, 4'b0010, 4'b0010, 1'b1);
    step("rs2", 4'b0010, 4'b0000, 1'b1, 2'd1, 8'h92, 4'b0010, 4'b0010, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_zero("rs_async");
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    step("ra0", 4'b0101, 4'b0101, 1'b1, 2'd0, 8'hA1, 4'b0000, 4'b0000, 1'b1);
    step("ra1", 4'b0101, 4'b0101, 1'b1, 2'd0, 8'hA1, 4'b0001, 4'b0001, 1'b1);
    step("ra2", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'h00, 4'b0000, 4'b0000, 1'b1);
    step("ra3", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'h00, 4'b0000, 4'b0000, 1'b1);

    // Synchronous clear mid-burst on source 3: no ack in the clear cycle, effect at the edge.
    step("cl0", 4'b1000, 4'b0000, 1'b1, 2'd3, 8'hB1, 4'b0000, 4'b0000, 1'b1);
    step("cl1", 4'b1000, 4'b0000, 1'b1, 2'd3, 8'hB1, 4'b1000, 4'b1000, 1'b1);
    step("cl2", 4'b1000, 4'b0000, 1'b1, 2'd3, 8'hB2, 4'b1000, 4'b1000, 1'b1);
    clear = 1'b1;
    step("cl3", 4'b1000, 4'b0000, 1'b1, 2'd3, 8'hB3, 4'b1000, 4'b0000, 1'b1);
    clear = 1'b0;
    #1;
    check_zero("cl_after");
    exp_q.delete();
    step("ca0", 4'b0101, 4'b0101, 1'b1, 2'd0, 8'hC1, 4'b0000, 4'b0000, 1'b1);
    step("ca1", 4'b0101, 4'b0101, 1'b1, 2'd0, 8'hC1, 4'b0001, 4'b0001, 1'b1);
    step("ca2", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'h00, 4'b0000, 4'b0000, 1'b1);
    step("ca3", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'h00, 4'b0000, 4'b0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_share_arbiter.md
# bus_share_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit output register among REQUESTERS upstream sources. Each source presents a request, data word and end-of-burst flag; the arbiter grants one source at a time, steers its data through an internal mux into a single output register, and acknowledges each beat accepted. It sits between multiple producers and one shared downstream consumer, using a valid/ready handshake on the output side.

## Interface

- REQUESTERS, default 4: number of sources; at least 2.
- WIDTH, default 8: data width per beat.
- MAX_HOLD, default 4: maximum beats per grant before forced release; at least 1.

- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear; same effect as reset, taken on the clock edge; has priority over all other activity.
- req  input  [REQUESTERS-1:0]  per-source request; a source holds it high while it has a beat to offer.
- last  input  [REQUESTERS-1:0]  per-source end-of-burst flag; qualified by the accepted beat.
- data_in  input  [REQUESTERS-1:0][WIDTH-1:0]  per-source data.
- ack  output  [REQUESTERS-1:0]  combinational one-hot; ack[i]=1 means source i's beat is accepted this cycle.
- grant  output  [REQUESTERS-1:0]  registered one-hot current owner; all zero when idle.
- grant_id  output  $clog2(REQUESTERS)  index of the current owner; 0 when idle.
- out_valid  output  1  output register holds a valid beat.
- out_data  output  WIDTH  output register contents.
- out_ready  input  1  downstream accepts out_data this cycle when out_valid=1.

## Operation

- States: IDLE and GRANT.
- Round-robin pointer ptr: the index searched first. Reset value 0.
- IDLE: if any req is high, select the first requester at or after ptr, wrapping modulo REQUESTERS. Load grant and grant_id, set beat count to 0, and move to GRANT on the next edge. If no req is high, stay in IDLE. No ack is issued in IDLE.
- GRANT, with owner g: accept when req[g] && (!out_valid || out_ready). On acceptance, ack[g]=1, out_data <= data_in[g], out_valid <= 1, and beat count increments.
- If out_valid && out_ready with no acceptance, then out_valid <= 0 and out_data holds its value.
- Leave GRANT for IDLE, clearing grant to 0 and setting ptr <= (g+1) mod REQUESTERS, when any of the following occurs:
  - an accepted beat has last[g]=1;
  - an accepted beat is the MAX_HOLD-th beat of the grant;
  - req[g]=0, meaning the owner withdrew. In this case no beat is accepted that cycle.
- While in GRANT, req, last and data_in of non-owners are ignored, and their ack bits are 0.
- out_data is always sourced only from the granted requester via grant_id.
- Reset and clear set:
  - state=IDLE, ptr=0, beat count=0;
  - grant=0, grant_id=0;
  - out_valid=0, out_data=0.
- ack is 0 during reset and in the clear cycle.
- A beat in the output register is discarded on reset or clear, even mid-burst. A reset or clear mid-burst ends the burst with no ack that cycle; arbitration restarts from index 0.

## Timing

- Request to grant: req rises in cycle 0 while IDLE, and grant is visible in cycle 1.
- First ack occurs in cycle 1 if the output register is free or out_ready=1. out_valid rises in cycle 2.
- There is one idle bubble cycle between consecutive grants. Arbitration happens only in IDLE.
- Sustained throughput within a burst is one beat per cycle while out_ready=1.
- ack depends combinationally on req, out_valid and out_ready. There is no combinational path from data_in to any control output.
- Backpressure: when out_valid=1 and out_ready=0, out_data is held stable and no ack is issued.

## Test plan

- Single source, 3-beat burst: req[1]=1 with data 0x11, 0x22, 0x33, last on the third beat, out_ready=1.
  - grant=0010 in cycle 1; ack[1] in cycles 1–3; out_data sequence 0x11, 0x22, 0x33 in cycles 2–4.
  - grant=0 in cycle 4; ptr=2.
- Fairness: all four req held high, last=1 on every beat.
  - Grant order is 0,1,2,3,0, one beat each, with one IDLE cycle between grants.
- MAX_HOLD=4 truncation: only req[2] streams 6 beats with no last.
  - Acks on 4 beats, then IDLE for one cycle, then regrant to 2 for the remaining 2 beats.
  - The output sequence is unchanged.
- Backpressure: out_ready=0 for 3 cycles mid-burst.
  - out_data is held, out_valid=1, ack=0.
  - When out_ready returns, the next beat is accepted in that same cycle.
- Withdrawal: owner 3 drops req after 1 beat while req[0] is high.
  - Next edge returns to IDLE; the following edge grants 0 (ptr wrapped from 3 to 0).
- Reset, then clear, mid-burst: assert reset asynchronously between edges during a burst.
  - All outputs are 0 immediately.
  - After release, req[2] and req[0] both high give grant to 0.
  - Repeat the scenario with clear; it gives the same result, taking effect at the edge.
